// File: rtl/gate_reduce_pipe.sv
// Two-stage valid/ready pipeline that reduces NUM_IN masked operand channels
// with a selectable bitwise gate (AND/OR/XOR, their complements, BUF, NOT).
module gate_reduce_pipe #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_mask,
    input  logic [2:0]              in_mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [15:0]             out_count
);

    localparam logic [2:0] MODE_AND  = 3'd0;
    localparam logic [2:0] MODE_OR   = 3'd1;
    localparam logic [2:0] MODE_XOR  = 3'd2;
    localparam logic [2:0] MODE_NAND = 3'd3;
    localparam logic [2:0] MODE_NOR  = 3'd4;
    localparam logic [2:0] MODE_XNOR = 3'd5;
    localparam logic [2:0] MODE_BUF  = 3'd6;
    localparam logic [2:0] MODE_NOT  = 3'd7;

    // Masked channels already hold the identity value, so a plain fold is enough.
    function automatic logic [WIDTH-1:0] reduce_f(
        input logic [NUM_IN*WIDTH-1:0] ops,
        input logic [2:0]              mode
    );
        logic [WIDTH-1:0] v_and;
        logic [WIDTH-1:0] v_or;
        logic [WIDTH-1:0] v_xor;
        logic [WIDTH-1:0] res;
        v_and = {WIDTH{1'b1}};
        v_or  = {WIDTH{1'b0}};
        v_xor = {WIDTH{1'b0}};
        for (int k = 0; k < NUM_IN; k++) begin
            v_and = v_and & ops[k*WIDTH +: WIDTH];
            v_or  = v_or  | ops[k*WIDTH +: WIDTH];
            v_xor = v_xor ^ ops[k*WIDTH +: WIDTH];
        end
        case (mode)
            MODE_AND:  res = v_and;
            MODE_OR:   res = v_or;
            MODE_XOR:  res = v_xor;
            MODE_NAND: res = ~v_and;
            MODE_NOR:  res = ~v_or;
            MODE_XNOR: res = ~v_xor;
            MODE_BUF:  res = ops[WIDTH-1:0];
            MODE_NOT:  res = ~ops[WIDTH-1:0];
            default:   res = v_and;
        endcase
        return res;
    endfunction

    logic                    w_advance;
    logic [WIDTH-1:0]        w_fill;
    logic [NUM_IN*WIDTH-1:0] w_masked;

    logic                    r_s1_valid;
    logic [NUM_IN*WIDTH-1:0] r_s1_data;
    logic [2:0]              r_s1_mode;
    logic                    r_s2_valid;
    logic [WIDTH-1:0]        r_s2_data;
    logic [15:0]             r_count;

    assign w_advance = !r_s2_valid || out_ready;
    assign in_ready  = w_advance;
    assign out_valid = r_s2_valid;
    assign out_data  = r_s2_data;
    assign out_count = r_count;

    // Replace disabled channels with the identity of the selected gate.
    always_comb begin
        w_fill   = {WIDTH{1'b0}};
        w_masked = {(NUM_IN*WIDTH){1'b0}};
        case (in_mode)
            MODE_AND, MODE_NAND: w_fill = {WIDTH{1'b1}};
            default:             w_fill = {WIDTH{1'b0}};
        endcase
        for (int k = 0; k < NUM_IN; k++) begin
            if (in_mask[k]) begin
                w_masked[k*WIDTH +: WIDTH] = in_data[k*WIDTH +: WIDTH];
            end else begin
                w_masked[k*WIDTH +: WIDTH] = w_fill;
            end
        end
    end

    // Pipeline stages and delivery counter; both stages stall together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= {(NUM_IN*WIDTH){1'b0}};
            r_s1_mode  <= 3'd0;
            r_s2_valid <= 1'b0;
            r_s2_data  <= {WIDTH{1'b0}};
            r_count    <= 16'd0;
        end else begin
            if (w_advance) begin
                r_s1_valid <= in_valid;
                r_s1_data  <= w_masked;
                r_s1_mode  <= in_mode;
                r_s2_valid <= r_s1_valid;
                r_s2_data  <= reduce_f(r_s1_data, r_s1_mode);
            end
            if (r_s2_valid && out_ready) begin
                r_count <= r_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_gate_reduce_pipe.sv
// Directed scoreboard bench for gate_reduce_pipe (WIDTH=8, NUM_IN=4).
module tb_gate_reduce_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic [3:0]  in_mask;
    logic [2:0]  in_mode;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_count;

    int         total = 0;
    int         bad = 0;
    int         delivered = 0;
    int         base;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    gate_reduce_pipe #(.WIDTH(8), .NUM_IN(4)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_mask(in_mask), .in_mode(in_mode),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_count(out_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Per-bit reference: gather enabled bits, then apply the gate.
    function automatic logic [7:0] model(input logic [31:0] d, input logic [3:0] m,
                                         input logic [2:0] md);
        logic [7:0] r;
        logic all1, any1, par, b0;
        for (int b = 0; b < 8; b++) begin
            all1 = 1'b1; any1 = 1'b0; par = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (m[k]) begin
                    all1 = all1 & d[k*8+b];
                    any1 = any1 | d[k*8+b];
                    par  = par ^ d[k*8+b];
                end
            end
            b0 = m[0] & d[b];
            case (md)
                3'd0: r[b] = all1;
                3'd1: r[b] = any1;
                3'd2: r[b] = par;
                3'd3: r[b] = ~all1;
                3'd4: r[b] = ~any1;
                3'd5: r[b] = ~par;
                3'd6: r[b] = b0;
                default: r[b] = ~b0;
            endcase
        end
        return r;
    endfunction

    // Enter just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [31:0] d, input logic [3:0] m, input logic [2:0] md,
                        input logic [7:0] exp);
        int n;
        n = 0;
        in_data = d; in_mask = m; in_mode = md; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (in_ready) begin
            @(posedge clk);
            sb.push_back(exp);
            #1;
        end else begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
        end
    endtask

    task automatic drain();
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    // Output side of the scoreboard: every delivery must match the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                chk("out_data", 32'(out_data), 32'(sb.pop_front()));
            end
            delivered++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [3:0]  m;
        logic [2:0]  md;

        rst = 1'b1; in_valid = 1'b1; in_data = 32'h0000_00AA; in_mask = 4'hF;
        in_mode = 3'd6; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // First cycle after reset: AND of FF,0F,3C,F0 and 2-cycle latency
        send(32'hF03C_0FFF, 4'hF, 3'd0, 8'h00);
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat2_valid", 32'(out_valid), 32'd1);
        chk("lat2_data", 32'(out_data), 32'h00);
        @(posedge clk); #1;
        chk("count_first", 32'(out_count), 32'd1);

        // Back-to-back directed patterns with per-transaction mode changes
        send(32'h0804_0201, 4'b0101, 3'd2, 8'h05);
        send(32'h0804_0201, 4'b0101, 3'd5, 8'hFA);
        send(32'h1234_5678, 4'b0000, 3'd0, 8'hFF);
        send(32'h1234_5678, 4'b0000, 3'd1, 8'h00);
        send(32'h1234_5678, 4'b0000, 3'd2, 8'h00);
        send(32'h1234_5678, 4'b0000, 3'd3, 8'h00);
        send(32'h1234_5678, 4'b0000, 3'd4, 8'hFF);
        send(32'h1234_5678, 4'b0000, 3'd5, 8'hFF);
        send(32'h1234_565A, 4'b0001, 3'd6, 8'h5A);
        send(32'h1234_565A, 4'b0001, 3'd7, 8'hA5);
        send(32'h1234_565A, 4'b1110, 3'd7, 8'hFF);
        send(32'h1234_565A, 4'b1110, 3'd6, 8'h00);
        for (int i = 0; i < 24; i++) begin
            d = $urandom; m = 4'($urandom_range(0, 15)); md = 3'($urandom_range(0, 7));
            send(d, m, md, model(d, m, md));
        end
        drain();
        chk("count_directed", 32'(out_count), 32'(delivered));

        // Backpressure: out_ready low for four cycles while inputs stream in
        base = delivered;
        send(32'h0F0F_0F0F, 4'hF, 3'd1, 8'h0F);
        fork
            begin
                send(32'hFF7F_3F1F, 4'hF, 3'd0, 8'h1F);
                send(32'h0000_0011, 4'b0001, 3'd4, 8'hEE);
                send(32'hFFFF_FFFF, 4'hF, 3'd3, 8'h00);
            end
            begin
                out_ready = 1'b0;
                @(negedge clk);
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_in_ready", 32'(in_ready), 32'd0);
                    chk("bp_out_valid", 32'(out_valid), 32'd1);
                    chk("bp_hold_data", 32'(out_data), 32'h0F);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_delivered", 32'(delivered - base), 32'd4);
        chk("bp_count", 32'(out_count), 32'(delivered));

        // Reset with two transactions in flight
        send(32'h0000_00C3, 4'hF, 3'd6, 8'hC3);
        send(32'h0000_003C, 4'hF, 3'd6, 8'h3C);
        rst = 1'b1; in_valid = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        delivered = 0;
        @(negedge clk);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_count", 32'(out_count), 32'd0);
        drain();
        chk("post_rst_count", 32'(out_count), 32'd0);

        // Counter wrap after 65536 deliveries
        for (int i = 0; i < 65535; i++) begin
            d = $urandom; m = 4'($urandom_range(0, 15)); md = 3'($urandom_range(0, 7));
            send(d, m, md, model(d, m, md));
        end
        drain();
        chk("count_ffff", 32'(out_count), 32'h0000_FFFF);
        send(32'h0102_0304, 4'hF, 3'd2, 8'h04);
        drain();
        chk("count_wrap", 32'(out_count), 32'h0000_0000);
        chk("wrap_delivered", 32'(delivered), 32'd65536);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
